// File: rtl/ca5_q2_seq_detector.sv
// Serial 1-0-0-1 sequence detector: Moore FSM, overlapping matches, one-cycle pulse on w.
// The state register resets asynchronously on rst low; w decodes the state only.
`timescale 1ns/1ps
module ca5_q2_seq_detector (
  input  logic clk,
  input  logic rst,
  input  logic j,
  output logic w
);

  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100
  } state_t;

  state_t r_state;
  state_t w_state_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S0;
    end else begin
      r_state <= w_state_next;
    end
  end

  // S4 reuses its trailing 1 as the start of the next pattern, so it behaves like S1.
  always_comb begin
    w_state_next = S0;
    case (r_state)
      S0:      w_state_next = j ? S1 : S0;
      S1:      w_state_next = j ? S1 : S2;
      S2:      w_state_next = j ? S1 : S3;
      S3:      w_state_next = j ? S4 : S0;
      S4:      w_state_next = j ? S1 : S2;
      default: w_state_next = S0;
    endcase
  end

  assign w = (r_state == S4);

endmodule

// File: tb/tb_ca5_q2_seq_detector.sv
// Bench for ca5_q2_seq_detector: vector tables, reset corner cases and a random stream
// checked against a last-four-samples reference, through an expected-value queue.
`timescale 1ns/1ps
module tb_ca5_q2_seq_detector;

  logic clk;
  logic rst;
  logic j;
  logic w;

  ca5_q2_seq_detector dut (
    .clk (clk),
    .rst (rst),
    .j   (j),
    .w   (w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   grp;
    logic jv;
    logic exp_w;
  } vec_t;

  vec_t tbl[$];
  logic exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [3:0] hist;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: w=%b expected=%b at t=%0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: w=%b at t=%0t", name, act, $time);
    end
  endtask

  // Called on a falling edge: drive j, let one rising edge sample it, check on the next falling edge.
  task automatic step(input logic jv, input logic exp, input string name);
    logic e;
    j = jv;
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty, w=%b", name, w);
    end else begin
      e = exp_q.pop_front();
      check_bit(name, w, e);
    end
  endtask

  // Reset pulse placed between edges; w must drop before any clock edge arrives.
  task automatic pulse_reset(input string name);
    rst = 1'b0;
    #1;
    check_bit(name, w, 1'b0);
    #1;
    rst = 1'b1;
    hist = 4'b0000;
  endtask

  task automatic add(input int g, input logic jv, input logic ew);
    vec_t v;
    v.grp = g;
    v.jv = jv;
    v.exp_w = ew;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev_grp;
    logic jv;

    // group 0: main stream 1,1,0,0,1,0,0,1,0,1
    add(0,1,0); add(0,1,0); add(0,0,0); add(0,0,0); add(0,1,1);
    add(0,0,0); add(0,0,0); add(0,1,1); add(0,0,0); add(0,1,0);
    // group 1: back-to-back overlap 1,0,0,1,0,0,1
    add(1,1,0); add(1,0,0); add(1,0,0); add(1,1,1); add(1,0,0); add(1,0,0); add(1,1,1);
    // group 2: near misses 1,0,1,0,0,0,1,1,0,1 then 0,0,1
    add(2,1,0); add(2,0,0); add(2,1,0); add(2,0,0); add(2,0,0);
    add(2,0,0); add(2,1,0); add(2,1,0); add(2,0,0); add(2,1,0);
    add(2,0,0); add(2,0,0); add(2,1,1);

    rst = 1'b0;
    j = 1'b0;
    hist = 4'b0000;
    #1;
    check_bit("reset_state", w, 1'b0);

    // Reset held across 10 edges while j carries a stream that would otherwise match.
    for (int i = 0; i < 10; i++) begin
      j = (i inside {0, 1, 4, 7, 9}) ? 1'b1 : 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_bit("reset_held", w, 1'b0);
    end
    rst = 1'b1;

    prev_grp = -1;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].grp != prev_grp) begin
        if (prev_grp >= 0) pulse_reset("grp_reset");
        prev_grp = tbl[i].grp;
      end
      step(tbl[i].jv, tbl[i].exp_w, $sformatf("tbl_g%0d_v%0d", tbl[i].grp, i));
    end

    // Reset while in S3: the partial prefix must be discarded.
    pulse_reset("pre_s3");
    step(1'b1, 1'b0, "s3_a");
    step(1'b0, 1'b0, "s3_b");
    step(1'b0, 1'b0, "s3_c");
    pulse_reset("async_in_s3");
    step(1'b1, 1'b0, "after_s3_rst_j1");
    step(1'b0, 1'b0, "after_s3_rst_j0a");
    step(1'b0, 1'b0, "after_s3_rst_j0b");
    step(1'b1, 1'b1, "after_s3_rst_match");

    // Reset while in S4: w must fall without a clock edge.
    pulse_reset("pre_s4");
    step(1'b1, 1'b0, "s4_a");
    step(1'b0, 1'b0, "s4_b");
    step(1'b0, 1'b0, "s4_c");
    step(1'b1, 1'b1, "s4_match");
    pulse_reset("async_in_s4");
    step(1'b1, 1'b0, "after_s4_rst_j1");

    // Random stream with occasional reset pulses; a match is exactly "last four samples = 1001".
    pulse_reset("rand_start");
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 39) == 0) pulse_reset("rand_rst");
      jv = 1'($urandom_range(0, 1));
      hist = {hist[2:0], jv};
      step(jv, (hist == 4'b1001), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ca5_q2_seq_detector.md
# ca5_q2_seq_detector

Synchronous Moore-type serial sequence detector that watches a 1-bit input stream `j` and raises `w` for one clock cycle each time the pattern 1-0-0-1 completes, with overlapping matches allowed. It is the CA5 Q2 block and exists in two forms with identical ports and cycle behaviour:

- `CA5_Q2_pre_synth`: the behavioural RTL.
- `CA5_Q2`: the synthesized gate-level netlist.

Verification runs both side by side and compares `w`.

## Interface

Parameters: none.

Ports:
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst`  input  1  reset; one clock; reset is asynchronous and active-low (`rst`=0 forces reset immediately, independent of `clk`).
- `j`    input  1  serial data bit, sampled on each rising edge of `clk`.
- `w`    output 1  detect flag; 1 only while the FSM is in the match state.

## Operation

- Moore FSM with 5 states, 3-bit binary state register:
  - S0=000: idle, no useful prefix.
  - S1=001: seen "1".
  - S2=010: seen "10".
  - S3=011: seen "100".
  - S4=100: seen "1001", match.
- Transitions, evaluated on the sampled `j`:
  - S0: j=1 → S1; j=0 → S0.
  - S1: j=1 → S1; j=0 → S2.
  - S2: j=1 → S1; j=0 → S3.
  - S3: j=1 → S4; j=0 → S0.
  - S4: j=1 → S1; j=0 → S2. Overlap: the final 1 of a match starts the next pattern.
- Unused codes 101, 110, 111: `w`=0 and next state S0 for any `j`.
- Output decode: `w` = 1 iff state == S4. `w` is a function of the state only; `j` has no combinational path to `w`.
- `CA5_Q2` (netlist) matches `CA5_Q2_pre_synth` cycle-for-cycle on `w` for every input sequence and every reset sequence.

## Timing

- Reset:
  - `rst`=0 sets the state to S0 asynchronously; `w`=0 within propagation delay, without waiting for a clock edge.
  - While `rst`=0, the state stays S0 and `w`=0 regardless of `clk` and `j`.
  - Once `rst`=1, the first rising edge samples `j` normally.
- Reset mid-operation: any partial prefix (S1–S4) is discarded; detection restarts from S0.
- `j` must meet setup/hold around the rising edge of `clk`; changes between edges have no effect.
- Latency: the edge that samples the final 1 of "1001" moves the FSM to S4. `w` goes high after clock-to-Q and stays high for exactly one cycle, until the next rising edge.
- Consecutive matches:
  - Minimum spacing between `w` pulses is 3 cycles (stream 1001001 → matches at the 4th and 7th samples).
  - `w` is never high two cycles in a row.
- No enable and no handshake; one sample per clock.

## Test plan

- Reset held: `rst`=0 for 10 edges while `j` toggles 1,1,0,0,1,0,0,1,0,1 → `w`=0 throughout, state S0.
- Main stream: release `rst`, then apply `j` = 1,1,0,0,1,0,0,1,0,1 on edges 1–10 → `w`=1 only after edges 5 and 8, each for one cycle; otherwise 0.
- Overlap, back-to-back: `j` = 1,0,0,1,0,0,1 → `w`=1 after edges 4 and 7 only.
- Near-misses: `j` = 1,0,1,0,0,0,1,1,0,1 → `w` stays 0, because 1000 falls back to S0 and 1101 fails. Then `j` = 0,0,1 → `w`=1 after that final edge.
- Asynchronous reset mid-pattern:
  - Apply 1,0,0 to reach S3, then pulse `rst`=0 between edges → `w`=0 immediately.
  - Release `rst`, apply `j`=1 → state S1, `w`=0; no false match.
- Equivalence: drive ≥1000 random `j` bits, with random `rst` pulses, into `CA5_Q2` and `CA5_Q2_pre_synth` in parallel → `w` identical at every sample point, 0.5 cycle after each edge.
